// File: rtl/fm7_video_pkg.sv
// Shared raster timing constants and helpers for the FM-7 video path.
//   DEF_*        default NTSC/PAL timing values used by fm7_video_timing
//   sync_pol_e   sync polarity selector
//   span_total   sum of active + porch + sync spans (pixels or lines)
//   max_u        larger of two unsigned values
//   sync_level   output level of a sync pin for a given polarity and active state
package fm7_video_pkg;

    localparam int unsigned DEF_CE_DIV   = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 64;
    localparam int unsigned DEF_H_BP     = 80;
    localparam int unsigned DEF_V_ACTIVE = 200;
    localparam int unsigned DEF_V_SYNC   = 3;
    localparam int unsigned DEF_V_FP_N   = 22;
    localparam int unsigned DEF_V_BP_N   = 37;
    localparam int unsigned DEF_V_FP_P   = 47;
    localparam int unsigned DEF_V_BP_P   = 62;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Total span of one line or one frame.
    function automatic int unsigned span_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Pin level for a sync output: the polarity level when active, its inverse otherwise.
    function automatic logic sync_level(input sync_pol_e pol, input logic active);
        return active ? logic'(pol) : ~logic'(pol);
    endfunction

endpackage

// File: rtl/fm7_ce_div.sv
// Clock-enable divider: ce is high for one clk out of every DIV.
//   clk       system clock
//   reset     synchronous active-high reset
//   ce        registered enable, first high DIV cycles after reset release
//   ce_pre_c  combinational look-ahead: ce will be high in the next cycle
module fm7_ce_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic ce,
    output logic ce_pre_c
);

    localparam int unsigned     DW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q;

    if (DIV < 2) begin : g_bad_div
        $error("fm7_ce_div: DIV must be at least 2");
    end

    assign ce_pre_c = (div_q == LAST);

    // Divider wraps on its last count; ce is that wrap, registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            ce    <= 1'b0;
        end else begin
            ce    <= ce_pre_c;
            div_q <= ce_pre_c ? '0 : div_q + DW'(1);
        end
    end

endmodule

// File: rtl/fm7_video_timing.sv
// Raster timing generator for the FM-7 core with run-time NTSC/PAL vertical timing.
//   clk          system clock
//   reset        synchronous active-high reset
//   pal          mode request (0 NTSC, 1 PAL), honoured only at a frame wrap
//   ce_pix       pixel clock enable
//   hcount       pixel x, 0..H_TOTAL-1
//   vcount       line y, 0..V_TOTAL-1 of the mode in force
//   HBlank       hcount >= H_ACTIVE
//   VBlank       vcount >= V_ACTIVE
//   HSync/VSync  sync pulses, polarity set by HS_POL/VS_POL
//   de           active display area
//   frame_start  one-clk strobe with ce_pix at pixel (0,0)
//   pal_active   mode currently in force
//   video        XOR test pattern inside the active area, 0 elsewhere
module fm7_video_timing
    import fm7_video_pkg::*;
#(
    parameter int unsigned CE_DIV   = DEF_CE_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_FP_N   = DEF_V_FP_N,
    parameter int unsigned V_BP_N   = DEF_V_BP_N,
    parameter int unsigned V_FP_P   = DEF_V_FP_P,
    parameter int unsigned V_BP_P   = DEF_V_BP_P,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    localparam int unsigned H_TOTAL   = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL_N = span_total(V_ACTIVE, V_FP_N, V_SYNC, V_BP_N),
    localparam int unsigned V_TOTAL_P = span_total(V_ACTIVE, V_FP_P, V_SYNC, V_BP_P),
    localparam int unsigned HCW       = $clog2(H_TOTAL),
    localparam int unsigned VCW       = $clog2(max_u(V_TOTAL_N, V_TOTAL_P))
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pal,
    output logic           ce_pix,
    output logic [HCW-1:0] hcount,
    output logic [VCW-1:0] vcount,
    output logic           HBlank,
    output logic           VBlank,
    output logic           HSync,
    output logic           VSync,
    output logic           de,
    output logic           frame_start,
    output logic           pal_active,
    output logic [7:0]     video
);

    // Thresholds at counter width; every end value is below the wrap value
    // because the back porches are non-zero.
    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] HB_START   = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_START   = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END     = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] VB_START   = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_LAST_N   = VCW'(V_TOTAL_N - 1);
    localparam logic [VCW-1:0] V_LAST_P   = VCW'(V_TOTAL_P - 1);
    localparam logic [VCW-1:0] VS_START_N = VCW'(V_ACTIVE + V_FP_N);
    localparam logic [VCW-1:0] VS_END_N   = VCW'(V_ACTIVE + V_FP_N + V_SYNC);
    localparam logic [VCW-1:0] VS_START_P = VCW'(V_ACTIVE + V_FP_P);
    localparam logic [VCW-1:0] VS_END_P   = VCW'(V_ACTIVE + V_FP_P + V_SYNC);

    localparam sync_pol_e HS_POL_E = HS_POL ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
    localparam sync_pol_e VS_POL_E = VS_POL ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;

    if (CE_DIV < 2 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_SYNC == 0 ||
        V_FP_N == 0 || V_BP_N == 0 || V_FP_P == 0 || V_BP_P == 0) begin : g_bad_cfg
        $error("fm7_video_timing: CE_DIV < 2 or a zero porch/sync width");
    end

    logic           ce_pre_c;
    logic [HCW-1:0] h_nxt;
    logic [VCW-1:0] v_nxt;
    logic           pal_nxt;
    logic [VCW-1:0] v_last;
    logic [VCW-1:0] vs_start;
    logic [VCW-1:0] vs_end;
    logic           hblank_d;
    logic           vblank_d;
    logic           hsync_on;
    logic           vsync_on;
    logic           de_d;
    logic           fs_d;
    logic [7:0]     video_d;

    fm7_ce_div #(
        .DIV (CE_DIV)
    ) u_ce_div (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce_pix),
        .ce_pre_c (ce_pre_c)
    );

    // Next raster position; the mode request is latched only on the full-frame wrap.
    always_comb begin
        h_nxt   = hcount;
        v_nxt   = vcount;
        pal_nxt = pal_active;
        v_last  = pal_active ? V_LAST_P : V_LAST_N;
        if (ce_pix) begin
            if (hcount == H_LAST) begin
                h_nxt = '0;
                if (vcount == v_last) begin
                    v_nxt   = '0;
                    pal_nxt = pal;
                end else begin
                    v_nxt = vcount + VCW'(1);
                end
            end else begin
                h_nxt = hcount + HCW'(1);
            end
        end
    end

    // Decode from the next position so registered outputs line up with the counters.
    always_comb begin
        vs_start = pal_nxt ? VS_START_P : VS_START_N;
        vs_end   = pal_nxt ? VS_END_P   : VS_END_N;
        hblank_d = (h_nxt >= HB_START);
        vblank_d = (v_nxt >= VB_START);
        hsync_on = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vsync_on = (v_nxt >= vs_start) && (v_nxt < vs_end);
        de_d     = ~hblank_d & ~vblank_d;
        video_d  = de_d ? (8'(h_nxt) ^ 8'(v_nxt)) : 8'h00;
        // ce_pre_c marks the cycle before ce_pix, so the strobe lands with it.
        fs_d     = ce_pre_c && (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            pal_active  <= pal;
            HBlank      <= 1'b0;
            VBlank      <= 1'b0;
            HSync       <= sync_level(HS_POL_E, 1'b0);
            VSync       <= sync_level(VS_POL_E, 1'b0);
            de          <= 1'b1;
            frame_start <= 1'b0;
            video       <= 8'h00;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            pal_active  <= pal_nxt;
            HBlank      <= hblank_d;
            VBlank      <= vblank_d;
            HSync       <= sync_level(HS_POL_E, hsync_on);
            VSync       <= sync_level(VS_POL_E, vsync_on);
            de          <= de_d;
            frame_start <= fs_d;
            video       <= video_d;
        end
    end

endmodule
